// File: rtl/car_queue_dispatch.sv
// Purpose : count cars waiting at one approach and hand them one at a time to the
//           lane animator (add_car / decrement_car handshake) while the light is green.
// Latency : arrival counted 1 cycle after its rising edge; add_car rises 1 cycle after
//           IDLE sees green with cars waiting, drops 1 cycle after the ack.
// Backpr. : the animator throttles via decrement_car; an unanswered request is withdrawn
//           after ACK_TIMEOUT cycles (ack_error set). Arrivals into a full queue are dropped.
//
// Ports:
//   traffic_clk    clock, all logic on posedge
//   reset          synchronous, active-high
//   car_arrive     debounced arrival level; each rising edge is one car
//   light_green    approach may dispatch cars
//   decrement_car  1-cycle ack from animator: car accepted
//   add_car        registered request to animator
//   car_count      cars currently waiting
//   queue_empty    car_count == 0
//   queue_full     car_count == MAX_CARS
//   car_dropped    1-cycle pulse, arrival lost because queue was full
//   ack_error      sticky, a request timed out; cleared only by reset
module car_queue_dispatch #(
    parameter int CNT_W       = 4,
    parameter int MAX_CARS    = 15,
    parameter int GAP_CYCLES  = 3,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic             traffic_clk,
    input  logic             reset,
    input  logic             car_arrive,
    input  logic             light_green,
    input  logic             decrement_car,
    output logic             add_car,
    output logic [CNT_W-1:0] car_count,
    output logic             queue_empty,
    output logic             queue_full,
    output logic             car_dropped,
    output logic             ack_error
);

    // One timer serves both the ack timeout (REQUEST) and the gap (GAP).
    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_CARS);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        GAP
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             car_arrive_q;
    logic             arr;
    logic             ack_valid;
    logic             arr_accepted;

    assign queue_empty  = (car_count == '0);
    assign queue_full   = (car_count == FULL_CNT);
    assign arr          = car_arrive & ~car_arrive_q;
    // An ack with nothing queued is ignored so the counter never wraps.
    assign ack_valid    = decrement_car & ~queue_empty;
    // A full queue still takes an arrival if a car leaves in the same cycle.
    assign arr_accepted = arr & (~queue_full | ack_valid);

    // Waiting-car counter and arrival edge detect. The edge register resets
    // to 1 so a button held through reset is not seen as an arrival.
    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            car_arrive_q <= 1'b1;
            car_count    <= '0;
            car_dropped  <= 1'b0;
        end else begin
            car_arrive_q <= car_arrive;
            car_dropped  <= arr & ~arr_accepted;
            if (arr_accepted && !ack_valid) begin
                car_count <= car_count + CNT_W'(1);
            end else if (!arr_accepted && ack_valid) begin
                car_count <= car_count - CNT_W'(1);
            end
        end
    end

    // Dispatch FSM. Late acks (IDLE/GAP) are handled by the counter alone.
    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            add_car   <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (light_green && !queue_empty) begin
                        state   <= REQUEST;
                        add_car <= 1'b1;
                    end
                end
                REQUEST: begin
                    // Ack takes priority over a simultaneous light drop.
                    if (decrement_car) begin
                        state   <= GAP;
                        add_car <= 1'b0;
                        timer   <= '0;
                    end else if (!light_green) begin
                        state   <= IDLE;
                        add_car <= 1'b0;
                    end else if (timer == ACK_LAST) begin
                        state     <= IDLE;
                        add_car   <= 1'b0;
                        ack_error <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                GAP: begin
                    // Keeps add_car low while the animator finishes its
                    // S1/S2/SPACE sequence and returns to READY.
                    if (timer == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    add_car <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_car_queue_dispatch.sv
// Purpose : directed bench for car_queue_dispatch with an expected-value queue.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at that point.
// Backpr. : the bench plays the animator, acking one cycle after add_car rises.
module tb_car_queue_dispatch;

    logic       traffic_clk = 1'b0;
    logic       reset;
    logic       car_arrive;
    logic       light_green;
    logic       decrement_car;
    logic       add_car;
    logic [3:0] car_count;
    logic       queue_empty;
    logic       queue_full;
    logic       car_dropped;
    logic       ack_error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    car_queue_dispatch dut (
        .traffic_clk   (traffic_clk),
        .reset         (reset),
        .car_arrive    (car_arrive),
        .light_green   (light_green),
        .decrement_car (decrement_car),
        .add_car       (add_car),
        .car_count     (car_count),
        .queue_empty   (queue_empty),
        .queue_full    (queue_full),
        .car_dropped   (car_dropped),
        .ack_error     (ack_error)
    );

    always #5 traffic_clk = ~traffic_clk;

    task automatic step();
        @(posedge traffic_clk);
        #1;
    endtask

    task automatic push_exp(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_underrun: observed %0d, nothing expected", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", t, obs, e);
    endtask

    task automatic expect_now(input string t, input logic [31:0] obs, input logic [31:0] e);
        push_exp(t, e);
        chk(obs);
    endtask

    initial begin
        int  rise_cyc;
        int  fall_cyc;
        int  pulses;
        int  exp_cnt;
        int  hi;
        bit  prev_add;
        bit  ack_pending;
        bit  have_fall;
        bit  done;

        // ---- 1: reset, button held through reset, three arrivals on red ----
        reset         = 1'b1;
        car_arrive    = 1'b1;
        light_green   = 1'b0;
        decrement_car = 1'b0;
        step();
        step();
        expect_now("rst_add_car",     32'(add_car),     32'd0);
        expect_now("rst_count",       32'(car_count),   32'd0);
        expect_now("rst_empty",       32'(queue_empty), 32'd1);
        expect_now("rst_full",        32'(queue_full),  32'd0);
        expect_now("rst_dropped",     32'(car_dropped), 32'd0);
        expect_now("rst_ack_error",   32'(ack_error),   32'd0);
        reset = 1'b0;
        step();
        expect_now("held_button_not_counted", 32'(car_count), 32'd0);
        car_arrive = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            car_arrive = 1'b1;
            step();
            push_exp("count_on_arrival", 32'(i + 1));
            chk(32'(car_count));
            car_arrive = 1'b0;
            step();
        end
        expect_now("red_no_request", 32'(add_car), 32'd0);

        // ---- 2: green, animator acks one cycle after each request ----
        exp_cnt     = 3;
        pulses      = 0;
        prev_add    = 1'b0;
        ack_pending = 1'b0;
        have_fall   = 1'b0;
        rise_cyc    = 0;
        fall_cyc    = 0;
        light_green = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (add_car && !prev_add) begin
                pulses++;
                if (have_fall) expect_now("low_cycles_between_requests", 32'(k - fall_cyc), 32'd4);
                rise_cyc      = k;
                ack_pending   = 1'b1;
                decrement_car = 1'b0;
            end else if (ack_pending) begin
                decrement_car = 1'b1;
                ack_pending   = 1'b0;
                exp_cnt--;
                push_exp("count_after_ack", 32'(exp_cnt));
            end else begin
                decrement_car = 1'b0;
            end
            if (!add_car && prev_add) begin
                chk(32'(car_count));
                expect_now("add_car_width", 32'(k - rise_cyc), 32'd2);
                fall_cyc  = k;
                have_fall = 1'b1;
            end
            prev_add = add_car;
        end
        decrement_car = 1'b0;
        expect_now("request_pulses", 32'(pulses),      32'd3);
        expect_now("drained_empty",  32'(queue_empty), 32'd1);

        // ack at zero count must not underflow
        decrement_car = 1'b1;
        step();
        decrement_car = 1'b0;
        step();
        expect_now("no_underflow", 32'(car_count), 32'd0);
        expect_now("idle_when_empty", 32'(add_car), 32'd0);

        // ---- 3: fill the queue on red, 16th arrival dropped ----
        light_green = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            car_arrive = 1'b1;
            step();
            push_exp("count_fill", 32'((i < 15) ? i + 1 : 15));
            chk(32'(car_count));
            push_exp("dropped_pulse", 32'((i == 15) ? 1 : 0));
            chk(32'(car_dropped));
            car_arrive = 1'b0;
            step();
        end
        expect_now("dropped_clears", 32'(car_dropped), 32'd0);
        expect_now("full_flag",      32'(queue_full),  32'd1);

        // ---- 4: arrival and ack in the same cycle while full ----
        car_arrive    = 1'b1;
        decrement_car = 1'b1;
        step();
        car_arrive    = 1'b0;
        decrement_car = 1'b0;
        expect_now("full_swap_count",   32'(car_count),   32'd15);
        expect_now("full_swap_dropped", 32'(car_dropped), 32'd0);
        step();

        // ---- 5: request never acked -> timeout ----
        hi          = 0;
        done        = 1'b0;
        light_green = 1'b1;
        for (int k = 0; k < 12 && !done; k++) begin
            step();
            if (add_car) hi++;
            else if (hi > 0) begin
                light_green = 1'b0;
                done        = 1'b1;
            end
        end
        expect_now("timeout_request_cycles", 32'(hi),        32'd4);
        expect_now("timeout_ack_error",      32'(ack_error), 32'd1);
        expect_now("timeout_count_kept",     32'(car_count), 32'd15);
        step();
        step();
        step();
        expect_now("ack_error_sticky", 32'(ack_error), 32'd1);
        expect_now("red_after_timeout", 32'(add_car), 32'd0);

        // ---- 6: withdraw on red, then reset in the middle of GAP ----
        light_green = 1'b1;
        step();
        expect_now("request_before_withdraw", 32'(add_car), 32'd1);
        light_green = 1'b0;
        step();
        expect_now("withdrawn",          32'(add_car),   32'd0);
        expect_now("withdraw_count",     32'(car_count), 32'd15);
        light_green = 1'b1;
        step();
        step();
        decrement_car = 1'b1;
        step();
        decrement_car = 1'b0;
        light_green   = 1'b0;
        expect_now("acked_request_low", 32'(add_car),   32'd0);
        expect_now("acked_count",       32'(car_count), 32'd14);
        step();
        reset = 1'b1;
        step();
        expect_now("midgap_rst_add_car",   32'(add_car),     32'd0);
        expect_now("midgap_rst_count",     32'(car_count),   32'd0);
        expect_now("midgap_rst_empty",     32'(queue_empty), 32'd1);
        expect_now("midgap_rst_full",      32'(queue_full),  32'd0);
        expect_now("midgap_rst_dropped",   32'(car_dropped), 32'd0);
        expect_now("midgap_rst_ack_error", 32'(ack_error),   32'd0);
        reset = 1'b0;
        step();
        step();
        expect_now("post_reset_idle", 32'(add_car), 32'd0);

        n_checks++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
